// File: rtl/booth_mul_arbiter_if.sv
// Request, response and multiplier-side signals of the shared Booth multiplier arbiter.
// slave is the arbiter's view; master is the view of the requesters, consumer and multiplier.
interface booth_mul_arbiter_if #(
    parameter int NREQ = 4,
    parameter int ID_W = 2
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [6*NREQ-1:0] req_m;
    logic [6*NREQ-1:0] req_q;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [ID_W-1:0]   rsp_id;
    logic [11:0]       rsp_result;
    logic              busy;
    logic              mul_start;
    logic [5:0]        mul_m;
    logic [5:0]        mul_q;
    logic [11:0]       mul_result;

    modport slave (
        input  req_valid, req_m, req_q, rsp_ready, mul_result,
        output req_ready, rsp_valid, rsp_id, rsp_result, busy, mul_start, mul_m, mul_q
    );

    modport master (
        output req_valid, req_m, req_q, rsp_ready, mul_result,
        input  req_ready, rsp_valid, rsp_id, rsp_result, busy, mul_start, mul_m, mul_q
    );
endinterface

// File: rtl/booth_mul_arbiter.sv
// Round-robin share of one sequential 6x6 signed multiplier; grant to response is MUL_LAT+2 cycles.
// One op in flight; the response is held stable until rsp_ready, and no grant is made outside IDLE.
module booth_mul_arbiter #(
    parameter int NREQ    = 4,
    parameter int ID_W    = 2,
    parameter int MUL_LAT = 9
) (
    input  logic               clk,
    input  logic               rst,
    booth_mul_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(MUL_LAT + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    logic [1:0]       state;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  id_r;
    logic [CNT_W-1:0] lat_cnt;
    logic [5:0]       mul_m_r;
    logic [5:0]       mul_q_r;
    logic             rsp_valid_r;
    logic [ID_W-1:0]  rsp_id_r;
    logic [11:0]      rsp_result_r;

    logic [ID_W-1:0]  cand [NREQ];
    logic             grant_vld;
    logic [ID_W-1:0]  grant_idx;
    logic [ID_W-1:0]  next_ptr;
    logic             take;
    logic [5:0]       sel_m;
    logic [5:0]       sel_q;

    // Candidate order starts at rr_ptr and wraps, so the lowest offset wins.
    always_comb begin
        for (int k = 0; k < NREQ; k++) begin
            cand[k] = ID_W'((int'(rr_ptr) + k) % NREQ);
        end
    end

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (bus.req_valid[cand[k]]) begin
                grant_vld = 1'b1;
                grant_idx = cand[k];
            end
        end
    end

    assign take     = (state == ST_IDLE) && grant_vld && !rst;
    assign next_ptr = (grant_idx == ID_W'(NREQ - 1)) ? '0 : grant_idx + ID_W'(1);

    always_comb begin
        sel_m         = '0;
        sel_q         = '0;
        bus.req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == ID_W'(i)) begin
                sel_m            = bus.req_m[6*i +: 6];
                sel_q            = bus.req_q[6*i +: 6];
                bus.req_ready[i] = take;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            rr_ptr       <= '0;
            id_r         <= '0;
            lat_cnt      <= '0;
            mul_m_r      <= '0;
            mul_q_r      <= '0;
            rsp_valid_r  <= 1'b0;
            rsp_id_r     <= '0;
            rsp_result_r <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (take) begin
                        mul_m_r <= sel_m;
                        mul_q_r <= sel_q;
                        id_r    <= grant_idx;
                        rr_ptr  <= next_ptr;
                        state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    lat_cnt <= CNT_W'(MUL_LAT - 1);
                    state   <= ST_WAIT;
                end
                ST_WAIT: begin
                    // The multiplier has no done flag; the count alone marks a valid product.
                    if (lat_cnt == '0) begin
                        rsp_result_r <= bus.mul_result;
                        rsp_id_r     <= id_r;
                        rsp_valid_r  <= 1'b1;
                        state        <= ST_RESP;
                    end else begin
                        lat_cnt <= lat_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.mul_start  = (state == ST_ISSUE);
    assign bus.busy       = (state != ST_IDLE);
    assign bus.mul_m      = mul_m_r;
    assign bus.mul_q      = mul_q_r;
    assign bus.rsp_valid  = rsp_valid_r;
    assign bus.rsp_id     = rsp_id_r;
    assign bus.rsp_result = rsp_result_r;
endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Bench for booth_mul_arbiter: directed and random ops against a scoreboard and a latency-accurate multiplier model.
module tb_booth_mul_arbiter;
    localparam int NREQ    = 4;
    localparam int ID_W    = 2;
    localparam int MUL_LAT = 9;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          exp_ptr = 0;
    int          mcnt    = MUL_LAT;
    logic [11:0] mprod   = '0;
    logic [11:0] mjunk   = '0;
    logic [11:0] last_res;
    logic [5:0]  m_a [NREQ];
    logic [5:0]  q_a [NREQ];
    int          gseq[$];

    booth_mul_arbiter_if #(.NREQ(NREQ), .ID_W(ID_W)) bus();

    booth_mul_arbiter #(.NREQ(NREQ), .ID_W(ID_W), .MUL_LAT(MUL_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    for (genvar i = 0; i < NREQ; i++) begin : g_pack
        assign bus.req_m[6*i +: 6] = m_a[i];
        assign bus.req_q[6*i +: 6] = q_a[i];
    end

    function automatic logic [11:0] prod12(input logic [5:0] m, input logic [5:0] q);
        int p;
        p = int'($signed(m)) * int'($signed(q));
        return p[11:0];
    endfunction

    // Multiplier model: product appears MUL_LAT cycles after the start cycle, garbage before that.
    always @(posedge clk) begin
        if (bus.mul_start) begin
            mcnt  <= 1;
            mprod <= prod12(bus.mul_m, bus.mul_q);
        end else if (mcnt < MUL_LAT) begin
            mcnt <= mcnt + 1;
        end
        mjunk <= 12'($urandom);
    end
    assign bus.mul_result = (mcnt >= MUL_LAT) ? mprod : (mprod ^ (mjunk | 12'h001));

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, observed hang expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic smp();
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return {31'b0, bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_result,
                bus.busy, bus.mul_start, bus.mul_m, bus.mul_q};
    endfunction

    function automatic int exp_grant(input logic [NREQ-1:0] vld);
        logic [NREQ-1:0] t;
        for (int off = 0; off < NREQ; off++) begin
            t = vld >> ((exp_ptr + off) % NREQ);
            if (t[0]) return (exp_ptr + off) % NREQ;
        end
        return -1;
    endfunction

    task automatic wig(input int g);
        logic [ID_W-1:0] gi;
        gi      = ID_W'(g);
        m_a[gi] = 6'($urandom);
        q_a[gi] = 6'($urandom);
    endtask

    task automatic rand_ops();
        for (int i = 0; i < NREQ; i++) begin
            m_a[i] = 6'($urandom);
            q_a[i] = 6'($urandom);
        end
    endtask

    // One operation from grant to response handshake; returns at the drive point after the handshake cycle.
    task automatic do_op(input logic [NREQ-1:0] vld, input bit keep, input int bp, input bit wiggle);
        int              g;
        bit              got;
        bit              ok;
        logic [5:0]      gm;
        logic [5:0]      gq;
        logic [11:0]     er;
        logic [ID_W-1:0] gi;
        g             = exp_grant(vld);
        bus.req_valid = vld;
        bus.rsp_ready = (bp == 0);
        smp();
        chk("idle_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        chk("idle_busy", 64'(bus.busy), 64'(0));
        got = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (bus.req_ready != '0) begin
                got = 1'b1;
                break;
            end
            tick();
            smp();
        end
        chk("grant_seen", 64'(got), 64'(1));
        if (!got || g < 0) return;
        chk("grant_onehot", 64'(bus.req_ready), 64'(1) << g);
        gseq.push_back(g);
        gi      = ID_W'(g);
        gm      = m_a[gi];
        gq      = q_a[gi];
        er      = prod12(gm, gq);
        exp_ptr = (g + 1) % NREQ;

        tick();
        if (!keep) bus.req_valid = bus.req_valid & ~(NREQ'(1) << g);
        if (wiggle) wig(g);
        smp();
        chk("issue_ctl", 64'({bus.mul_start, bus.busy, bus.req_ready}), 64'({1'b1, 1'b1, 4'b0}));
        chk("issue_ops", 64'({bus.mul_m, bus.mul_q}), 64'({gm, gq}));

        ok = 1'b1;
        for (int k = 2; k <= MUL_LAT + 1; k++) begin
            tick();
            if (wiggle) wig(g);
            smp();
            if (bus.mul_start !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.req_ready !== '0 ||
                bus.mul_m !== gm || bus.mul_q !== gq || bus.busy !== 1'b1) ok = 1'b0;
        end
        chk("wait_quiet", 64'(ok), 64'(1));

        tick();
        if (wiggle) wig(g);
        smp();
        chk("rsp_valid_rise", 64'(bus.rsp_valid), 64'(1));
        chk("rsp_id", 64'(bus.rsp_id), 64'(gi));
        chk("rsp_result", 64'(bus.rsp_result), 64'(er));
        last_res = bus.rsp_result;

        ok = 1'b1;
        for (int k = 1; k <= bp; k++) begin
            tick();
            if (wiggle) wig(g);
            bus.rsp_ready = (k == bp);
            smp();
            if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== gi || bus.rsp_result !== er ||
                bus.req_ready !== '0 || bus.mul_start !== 1'b0 ||
                bus.mul_m !== gm || bus.mul_q !== gq) ok = 1'b0;
        end
        if (bp > 0) chk("bp_hold", 64'(ok), 64'(1));
        tick();
    endtask

    task automatic do_reset();
        bus.req_valid = '0;
        rst = 1'b1;
        smp();
        chk("reset_outs", outs(), 64'(0));
        tick();
        rst     = 1'b0;
        exp_ptr = 0;
        tick();
    endtask

    initial begin
        int enc;
        bit ok;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            m_a[i] = '0;
            q_a[i] = '0;
        end
        smp();
        chk("reset_state", outs(), 64'(0));
        tick();
        rst = 1'b0;
        tick();

        // Single op and operand corners on requester 0
        m_a[0] = 6'd5;  q_a[0] = 6'h3D;
        do_op(4'b0001, 1'b0, 0, 1'b0);
        chk("single_const", 64'(last_res), 64'(12'hFF1));
        m_a[0] = 6'h20; q_a[0] = 6'h20;
        do_op(4'b0001, 1'b0, 0, 1'b0);
        chk("corner_neg_neg", 64'(last_res), 64'(12'h400));
        m_a[0] = 6'h1F; q_a[0] = 6'h20;
        do_op(4'b0001, 1'b0, 0, 1'b0);
        chk("corner_pos_neg", 64'(last_res), 64'(12'hC20));
        m_a[0] = 6'h00; q_a[0] = 6'd17;
        do_op(4'b0001, 1'b0, 0, 1'b0);
        chk("corner_zero", 64'(last_res), 64'(12'h000));

        // Round-robin from a fresh pointer, then restart with requester 1 dropped
        do_reset();
        gseq.delete();
        for (int r = 0; r < 4; r++) begin
            rand_ops();
            do_op(4'b1111, 1'b1, 0, 1'b0);
        end
        enc = 0;
        foreach (gseq[i]) enc = enc * 10 + gseq[i] + 1;
        chk("rr_order", 64'(enc), 64'(1234));
        gseq.delete();
        for (int r = 0; r < 4; r++) begin
            rand_ops();
            do_op(4'b1101, 1'b1, 0, 1'b0);
        end
        enc = 0;
        foreach (gseq[i]) enc = enc * 10 + gseq[i] + 1;
        chk("rr_restart", 64'(enc), 64'(1341));

        // Backpressure, then operand hold with wiggling inputs
        rand_ops();
        do_op(4'b0110, 1'b1, 5, 1'b0);
        rand_ops();
        do_op(4'b0001, 1'b0, 2, 1'b1);

        // Reset while waiting on the multiplier
        rand_ops();
        bus.req_valid = 4'b0010;
        bus.rsp_ready = 1'b1;
        smp();
        chk("rstop_grant", 64'(bus.req_ready), 64'(4'b0010));
        tick();
        bus.req_valid = '0;
        smp();
        chk("rstop_start", 64'(bus.mul_start), 64'(1));
        tick(); tick(); tick(); tick();
        rst = 1'b1;
        smp();
        chk("rstop_outs_zero", outs(), 64'(0));
        tick();
        rst     = 1'b0;
        exp_ptr = 0;
        ok      = 1'b1;
        for (int k = 0; k < 15; k++) begin
            tick();
            smp();
            if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0 || bus.mul_start !== 1'b0) ok = 1'b0;
        end
        chk("rstop_discarded", 64'(ok), 64'(1));
        tick();
        rand_ops();
        do_op(4'b1111, 1'b0, 0, 1'b0);
        rand_ops();
        do_op(4'b0100, 1'b0, 0, 1'b0);

        // Random traffic
        for (int r = 0; r < 20; r++) begin
            rand_ops();
            do_op(NREQ'($urandom_range(1, 15)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/booth_mul_arbiter.md
Name: booth_mul_arbiter

Overview:
- Shares one sequential 6x6 signed Booth multiplier among NREQ requesters.
- Round-robin arbitration over valid/ready request channels; one operation in flight at a time.
- Registers and holds operands for the whole run, pulses the multiplier start, and counts a fixed latency because the multiplier has no done flag.
- Captures the 12-bit product and returns it on a single response channel tagged with the requester ID, honouring backpressure.

Parameters:
NREQ, 4, number of requesters (2..8)
ID_W, 2, requester ID width, equals ceil(log2(NREQ))
MUL_LAT, 9, cycles from the mul_start cycle to the cycle whose closing edge samples mul_result. Must be at least the multiplier's full busy time.

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  reset; asynchronous, active-high
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  one-hot accept pulse; at most one bit high
req_m  in  6*NREQ  signed multiplicand, requester i at bits [6i+5:6i]
req_q  in  6*NREQ  signed multiplier, same packing
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumer ready
rsp_id  out  ID_W  index of the requester owning rsp_result
rsp_result  out  12  signed product
busy  out  1  high in every state except IDLE
mul_start  out  1  one-cycle start pulse to the multiplier
mul_m  out  6  multiplicand to the multiplier, held stable
mul_q  out  6  multiplier operand, held stable
mul_result  in  12  multiplier product output

Behaviour:
- Reset values: all outputs 0, state IDLE, rr_ptr 0, latency counter 0, operand/ID registers 0.
- States:
  - IDLE: no request valid -> stay. Any request valid -> grant g, the first requester with req_valid high searching upward from rr_ptr and wrapping modulo NREQ.
  - Grant cycle (combinational): req_ready[g]=1 in that same cycle.
  - On the grant edge: latch req_m[g] into mul_m, req_q[g] into mul_q, g into the ID register; set rr_ptr = (g+1) mod NREQ; go to ISSUE.
  - ISSUE: mul_start=1 for exactly this cycle; load counter with MUL_LAT-1; go to WAIT.
  - WAIT: decrement counter each cycle. When counter==0: capture mul_result into rsp_result, drive rsp_id from the ID register, set rsp_valid, go to RESP.
  - RESP: hold rsp_valid, rsp_id and rsp_result stable until rsp_ready is high. On that handshake edge: clear rsp_valid, go to IDLE.
- Timing: grant in cycle A -> mul_start in A+1 -> mul_result sampled at the end of cycle A+1+MUL_LAT -> rsp_valid first high in A+2+MUL_LAT (A+11 at the default).
- Minimum turnaround is one IDLE cycle after the response handshake before the next grant. No grant is issued in the RESP handshake cycle.
- mul_m and mul_q change only on a grant edge. They are stable through ISSUE, WAIT and RESP.
- mul_start is never high outside ISSUE, so there are never back-to-back starts.
- req_ready is only ever high in IDLE. A requester dropping req_valid before it is granted is legal and loses nothing.
- rsp_result is taken bit-exact from the multiplier, with no sign manipulation in this block.
- Reset mid-operation:
  - All state returns to reset values immediately, including any pending response.
  - The in-flight operation is discarded with no response.
  - rr_ptr returns to 0.
- NREQ=1 degenerates to grant 0 whenever valid.

Test Plan:
- Single op: requester 0 presents M=5, Q=-3 (6'h3D) -> req_ready[0] in cycle A, mul_start in A+1 only, rsp_valid in A+11, rsp_id=0, rsp_result=12'hFF1 (-15).
- Corner operands, one run each:
  - M=-32, Q=-32 -> 12'h400
  - M=31, Q=-32 -> 12'hC20
  - M=0, Q=17 -> 12'h000
- Round-robin: all four requesters hold req_valid high for 4 operations with rsp_ready tied high -> grants in order 0,1,2,3 and rsp_id sequence 0,1,2,3.
- Round-robin restart: drop requester 1 and continue -> grants resume from the pointer, giving order 0,2,3,0.
- Backpressure: hold rsp_ready low for 5 cycles after rsp_valid rises -> rsp_valid, rsp_id and rsp_result are unchanged for all 5 cycles; req_ready stays 0; mul_start stays 0. Raise rsp_ready -> rsp_valid falls next cycle and the next grant occurs no earlier than one cycle later.
- Operand hold: change req_m[0] and req_q[0] every cycle after the grant -> mul_m and mul_q stay at the granted values until RESP completes.
- Reset in WAIT: assert rst 4 cycles after mul_start -> all outputs go to 0 immediately; no response is ever produced for that op. After release, a request from requester 2 is granted and rsp_id=2.
